// File: rtl/fetch_predecode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_predecode: fetch PC, sync imem drive, predecode, IF/ID register |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_predecode #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] target_pc,
  input  logic        predict_result,
  input  logic        predict_fail,
  output logic [31:0] pc,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic        branch,
  output logic        predict,
  output logic        excp,
  output logic        sret,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_predict_pc,
  output logic        id_predict_result,
  output logic        id_valid
);

  localparam logic [6:0]  c_OP_JAL   = 7'b1101111;
  localparam logic [6:0]  c_OP_JALR  = 7'b1100111;
  localparam logic [6:0]  c_OP_BR    = 7'b1100011;
  localparam logic [31:0] c_W_ECALL  = 32'h0000_0073;
  localparam logic [31:0] c_W_SRET   = 32'h1020_0073;

  logic [31:0] r_fpc;
  logic        r_f_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_predict_pc;
  logic        r_id_predict_result;
  logic        r_id_valid;

  // Re-issuing the held address on a stall keeps imem_rdata stable.
  always_comb begin
    if (rst || !r_f_valid) begin
      imem_addr = RESET_PC;
    end else if (stall) begin
      imem_addr = r_fpc;
    end else begin
      imem_addr = target_pc;
    end
  end

  always_ff @(posedge clk) begin
    r_fpc     <= imem_addr;
    r_f_valid <= !rst;
  end

  assign pc = r_fpc;

  always_comb begin
    branch  = 1'b0;
    predict = 1'b0;
    excp    = 1'b0;
    sret    = 1'b0;
    imm     = 32'd0;
    rs1     = 5'd0;
    rd      = 5'd0;
    if (r_f_valid) begin
      rs1 = imem_rdata[19:15];
      rd  = imem_rdata[11:7];
      case (imem_rdata[6:0])
        c_OP_JAL: begin
          branch = 1'b1;
          imm    = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};
        end
        c_OP_JALR: begin
          branch = 1'b1;
          imm    = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
        end
        c_OP_BR: begin
          branch  = 1'b1;
          predict = 1'b1;
          imm     = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                     imem_rdata[30:25], imem_rdata[11:8], 1'b0};
        end
        default: ;
      endcase
      if (imem_rdata == c_W_ECALL) begin
        excp = 1'b1;
      end else if (imem_rdata == c_W_SRET) begin
        excp = 1'b1;
        sret = 1'b1;
      end
    end
  end

  // IF/ID: a stall outranks a pending flush so the flush lands afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc             <= 32'd0;
      r_id_instr          <= NOP_INSTR;
      r_id_predict_pc     <= 32'd0;
      r_id_predict_result <= 1'b0;
      r_id_valid          <= 1'b0;
    end else if (stall) begin
      r_id_pc             <= r_id_pc;
      r_id_instr          <= r_id_instr;
      r_id_predict_pc     <= r_id_predict_pc;
      r_id_predict_result <= r_id_predict_result;
      r_id_valid          <= r_id_valid;
    end else if (predict_fail || !r_f_valid) begin
      r_id_pc             <= 32'd0;
      r_id_instr          <= NOP_INSTR;
      r_id_predict_pc     <= 32'd0;
      r_id_predict_result <= 1'b0;
      r_id_valid          <= 1'b0;
    end else begin
      r_id_pc             <= r_fpc;
      r_id_instr          <= imem_rdata;
      r_id_predict_pc     <= target_pc;
      r_id_predict_result <= predict_result;
      r_id_valid          <= 1'b1;
    end
  end

  assign id_pc             = r_id_pc;
  assign id_instr          = r_id_instr;
  assign id_predict_pc     = r_id_predict_pc;
  assign id_predict_result = r_id_predict_result;
  assign id_valid          = r_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_predecode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_predecode: predecode vector table plus IF/ID scoreboard      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_predecode;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, predict_result, predict_fail;
  logic [31:0] imem_addr, imem_rdata, target_pc, pc, imm;
  logic [4:0]  rs1, rd;
  logic        branch, predict, excp, sret;
  logic [31:0] id_pc, id_instr, id_predict_pc;
  logic        id_predict_result, id_valid;

  logic        use_tgt;
  logic [31:0] tgt_val;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;   // {branch, predict, excp, sret}
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rd;
  } pd_vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ppc;
    logic        pres;
    logic        valid;
  } ifid_t;

  pd_vec_t tbl [0:7];
  ifid_t   sb [$];

  fetch_predecode dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .target_pc(target_pc), .predict_result(predict_result),
    .predict_fail(predict_fail), .pc(pc), .imm(imm), .rs1(rs1), .rd(rd),
    .branch(branch), .predict(predict), .excp(excp), .sret(sret),
    .id_pc(id_pc), .id_instr(id_instr), .id_predict_pc(id_predict_pc),
    .id_predict_result(id_predict_result), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr[9:2]];

  // Predictor stand-in: sequential unless the test forces a target.
  always_comb target_pc = use_tgt ? tgt_val : pc + 32'd4;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] w,
                      input logic [31:0] pp, input logic pr, input logic v);
    ifid_t e;
    e.pc = p; e.instr = w; e.ppc = pp; e.pres = pr; e.valid = v;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push(32'd0, c_NOP, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    ifid_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got none expected an IF/ID record");
    end else begin
      e = sb.pop_front();
      chk("id_pc", id_pc, e.pc);
      chk("id_instr", id_instr, e.instr);
      chk("id_predict_pc", id_predict_pc, e.ppc);
      chk("id_predict_result", {31'd0, id_predict_result}, {31'd0, e.pres});
      chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
    end
  endtask

  task automatic chk_pd(input string nm, input pd_vec_t v);
    chk({nm, "_flags"}, {28'd0, branch, predict, excp, sret}, {28'd0, v.flags});
    chk({nm, "_imm"}, imm, v.imm);
    chk({nm, "_rs1"}, {27'd0, rs1}, {27'd0, v.rs1});
    chk({nm, "_rd"}, {27'd0, rd}, {27'd0, v.rd});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    pd_vec_t     zero_pd;
    tbl[0] = '{32'hFE208CE3, 4'b1100, 32'hFFFF_FFF8, 5'd1,  5'd25}; // beq x1,x2,-8
    tbl[1] = '{32'h100000EF, 4'b1000, 32'h0000_0100, 5'd0,  5'd1};  // jal x1,+0x100
    tbl[2] = '{32'hFFC102E7, 4'b1000, 32'hFFFF_FFFC, 5'd2,  5'd5};  // jalr x5,-4(x2)
    tbl[3] = '{32'h00000073, 4'b0010, 32'h0000_0000, 5'd0,  5'd0};  // ecall
    tbl[4] = '{32'h10200073, 4'b0011, 32'h0000_0000, 5'd0,  5'd0};  // sret
    tbl[5] = '{32'h00508193, 4'b0000, 32'h0000_0000, 5'd1,  5'd3};  // addi x3,x1,5
    tbl[6] = '{32'hFFDFF06F, 4'b1000, 32'hFFFF_FFFC, 5'd31, 5'd0};  // jal x0,-4
    tbl[7] = '{32'h00100073, 4'b0000, 32'h0000_0000, 5'd0,  5'd0};  // ebreak
    zero_pd = '{32'd0, 4'b0000, 32'd0, 5'd0, 5'd0};

    for (int i = 0; i < 256; i++) mem[i] = c_NOP;
    for (int i = 0; i < 8; i++) mem[i] = tbl[i].instr;

    rst = 1'b1; stall = 1'b0; predict_fail = 1'b0; predict_result = 1'b0;
    use_tgt = 1'b0; tgt_val = 32'd0;

    // Reset state: predecode must be gated off even though rdata holds a beq.
    push(32'd0, c_NOP, 32'd0, 1'b0, 1'b0); tick();
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk_pd("rst_pd", zero_pd);
    push(32'd0, c_NOP, 32'd0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    push_bubble(); tick();

    // Predecode vector table, straight-line fetch.
    for (int i = 0; i < 8; i++) begin
      a = 32'(i * 4);
      chk("tbl_pc", pc, a);
      chk_pd("tbl", tbl[i]);
      push(a, tbl[i].instr, a + 32'd4, 1'b0, 1'b1);
      tick();
    end

    // New program for the multi-cycle sequences.
    for (int i = 0; i < 256; i++) mem[i] = c_NOP;
    mem[0]  = 32'h00100093;
    mem[1]  = 32'h00200113;
    mem[2]  = 32'h00300193;
    mem[3]  = 32'h00400213;
    mem[4]  = 32'hFE208CE3;   // 0x10: beq x1,x2,-8
    mem[8]  = 32'h100000EF;   // 0x20: jal x1,+0x100
    mem[12] = 32'h00600313;   // 0x30
    mem[16] = 32'h00500293;   // 0x40
    mem[20] = 32'h00700393;   // 0x50
    rst = 1'b1;
    push(32'd0, c_NOP, 32'd0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    push_bubble(); tick();
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      chk("seq_pc", pc, a);
      push(a, mw(a), a + 32'd4, 1'b0, 1'b1);
      tick();
    end

    // beq predicted taken back to 0x8.
    chk("beq_pc", pc, 32'h10);
    chk("beq_flags", {30'd0, branch, predict}, 32'd3);
    chk("beq_imm", imm, 32'hFFFF_FFF8);
    use_tgt = 1'b1; tgt_val = 32'h8; predict_result = 1'b1;
    push(32'h10, 32'hFE208CE3, 32'h8, 1'b1, 1'b1); tick();
    chk("beq_next_pc", pc, 32'h8);

    // Predicted jump to the jal at 0x20, then the jal to 0x120 with no bubble.
    tgt_val = 32'h20;
    push(32'h8, mw(32'h8), 32'h20, 1'b1, 1'b1); tick();
    chk("jal_pc", pc, 32'h20);
    chk("jal_flags", {30'd0, branch, predict}, 32'd2);
    chk("jal_rd", {27'd0, rd}, 32'd1);
    chk("jal_imm", imm, 32'h100);
    tgt_val = 32'h120;
    #1;
    chk("jal_imem_addr", imem_addr, 32'h120);
    push(32'h20, 32'h100000EF, 32'h120, 1'b1, 1'b1); tick();
    chk("jal_next_pc", pc, 32'h120);
    use_tgt = 1'b0; predict_result = 1'b0;
    push(32'h120, c_NOP, 32'h124, 1'b0, 1'b1); tick();

    // Misprediction flush to 0x40: one bubble.
    predict_fail = 1'b1; use_tgt = 1'b1; tgt_val = 32'h40;
    push_bubble(); tick();
    chk("pf_pc", pc, 32'h40);
    predict_fail = 1'b0; use_tgt = 1'b0;
    push(32'h40, 32'h00500293, 32'h44, 1'b0, 1'b1); tick();

    // Get to 0x30, then stall 3 cycles with a flush pending.
    use_tgt = 1'b1; tgt_val = 32'h30; predict_result = 1'b1;
    push(32'h44, c_NOP, 32'h30, 1'b1, 1'b1); tick();
    chk("stall_pc0", pc, 32'h30);
    stall = 1'b1; predict_fail = 1'b1; tgt_val = 32'h50; predict_result = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_imem_addr", imem_addr, 32'h30);
      push(32'h44, c_NOP, 32'h30, 1'b1, 1'b1); tick();
      chk("stall_pc", pc, 32'h30);
      chk("stall_rd", {27'd0, rd}, 32'd6);
    end
    stall = 1'b0;
    push_bubble(); tick();
    chk("unstall_pc", pc, 32'h50);
    predict_fail = 1'b0; use_tgt = 1'b0;
    push(32'h50, 32'h00700393, 32'h54, 1'b0, 1'b1); tick();

    // Reset mid-operation.
    rst = 1'b1;
    push(32'd0, c_NOP, 32'd0, 1'b0, 1'b0); tick();
    chk("mrst_pc", pc, 32'd0);
    chk("mrst_imem_addr", imem_addr, 32'd0);
    chk("mrst_rs1", {27'd0, rs1}, 32'd0);
    rst = 1'b0;
    push_bubble(); tick();
    chk("mrst_pc1", pc, 32'd0);
    push(32'd0, 32'h00100093, 32'h4, 1'b0, 1'b1); tick();
    chk("mrst_pc2", pc, 32'h4);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
